dm_sba: RTL and testbench

System bus access (SBA) engine for the RISC-V debug module. It turns SBCS/SBAddress0/SBData0 accesses, already decoded by the DM register file, into single-beat requests on the system bus. It returns read data, maintains the address register including auto-increment, and reports busy and error status. It sits directly downstream of the DM CSR decode; its results feed the SBCS/SBData read-back path.

---
 rtl/dm_sba_pkg.sv | 17 +
 rtl/dm_sba_align.sv | 35 +++
 rtl/dm_sba.sv | 213 +++++++++++++++++++++
 tb/tb_dm_sba.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_sba_pkg.sv
// Shared types and constants for the debug-module system bus access engine.
// Used by dm_sba and dm_sba_align.
package dm_sba_pkg;

  typedef enum logic [2:0] {
    Idle,
    Read,
    Write,
    WaitRead,
    WaitWrite
  } sba_state_e;

  localparam logic [2:0] SbErrBadAddr = 3'd2;
  localparam logic [2:0] SbErrAlign   = 3'd3;
  localparam logic [2:0] SbErrSize    = 3'd4;

endpackage

// File: rtl/dm_sba_align.sv
// Byte-lane helper for SBA: byte enables, write-data replication and
// right-aligned, zero-extended read data from access size and offset.
module dm_sba_align #(
  parameter int BusWidth = 32,
  parameter int NB       = BusWidth / 8,
  parameter int OW       = $clog2(NB)
) (
  input  logic [2:0]          size_i,
  input  logic [OW-1:0]       offset_i,
  input  logic [BusWidth-1:0] wdata_i,
  input  logic [BusWidth-1:0] rdata_i,
  output logic [NB-1:0]       be_o,
  output logic [BusWidth-1:0] wdata_o,
  output logic [BusWidth-1:0] rdata_o
);

  int nb;
  int off;

  always_comb begin
    nb      = 1 << size_i;
    off     = int'(offset_i);
    be_o    = '0;
    wdata_o = '0;
    rdata_o = '0;
    for (int i = 0; i < NB; i++) begin
      be_o[i] = (i >= off) && (i < off + nb);
      wdata_o[8*i +: 8] = wdata_i[8*(i % nb) +: 8];
      if (i < nb && i + off < NB) begin
        rdata_o[8*i +: 8] = rdata_i[8*(i + off) +: 8];
      end
    end
  end

endmodule

// File: rtl/dm_sba.sv
// RISC-V debug module system bus access engine (single-beat requests).
// Define DM_SBA_BUS_ERR_EN to report r_err_i responses as error 2.
module dm_sba
  import dm_sba_pkg::*;
#(
  parameter int BusWidth = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  dmactive_i,
  input  logic [2:0]            sbaccess_i,
  input  logic                  sbreadonaddr_i,
  input  logic                  sbreadondata_i,
  input  logic                  sbautoincrement_i,
  input  logic [BusWidth-1:0]   sbaddress_i,
  input  logic                  sbaddress_write_valid_i,
  input  logic [BusWidth-1:0]   sbdata_i,
  input  logic                  sbdata_write_valid_i,
  input  logic                  sbdata_read_valid_i,
  output logic [BusWidth-1:0]   sbaddress_o,
  output logic [BusWidth-1:0]   sbdata_o,
  output logic                  sbdata_valid_o,
  output logic                  sbbusy_o,
  output logic                  sberror_valid_o,
  output logic [2:0]            sberror_o,
  output logic                  req_o,
  output logic                  we_o,
  output logic [BusWidth-1:0]   addr_o,
  output logic [BusWidth-1:0]   wdata_o,
  output logic [BusWidth/8-1:0] be_o,
  input  logic                  gnt_i,
  input  logic                  r_valid_i,
  input  logic [BusWidth-1:0]   r_rdata_i,
  input  logic                  r_err_i
);

  localparam int NB = BusWidth / 8;
  localparam int OW = $clog2(NB);

  sba_state_e state_q, state_d;
  logic [BusWidth-1:0] addr_q, addr_d;
  logic [BusWidth-1:0] data_q, data_d;
  logic [BusWidth-1:0] baddr_q, baddr_d;
  logic [BusWidth-1:0] wdata_q, wdata_d;
  logic [NB-1:0]       be_q, be_d;
  logic [2:0]          size_q, size_d;
  logic [OW-1:0]       off_q, off_d;
  logic [2:0]          err_q, err_d;
  logic req_q, req_d, we_q, we_d;
  logic dvalid_q, dvalid_d, evalid_q, evalid_d;
  logic abort_q, abort_d;

  logic                trig_wr, trig_rd;
  logic [BusWidth-1:0] taddr, lowmask, incr;
  logic [2:0]          al_size;
  logic [OW-1:0]       al_off;
  logic [NB-1:0]       al_be;
  logic [BusWidth-1:0] al_wdata, al_rdata;
  logic                resp_err;

`ifdef DM_SBA_BUS_ERR_EN
  assign resp_err = r_err_i;
`else
  logic unused_err;
  assign unused_err = r_err_i;
  assign resp_err   = 1'b0;
`endif

  assign trig_wr = dmactive_i & sbdata_write_valid_i;
  assign trig_rd = dmactive_i &
                   ((sbaddress_write_valid_i & sbreadonaddr_i) |
                    (sbdata_read_valid_i & sbreadondata_i));

  // Read-on-address targets the value being written, all else the register.
  assign taddr = (!sbdata_write_valid_i && sbaddress_write_valid_i &&
                  sbreadonaddr_i) ? sbaddress_i : addr_q;

  assign lowmask = (BusWidth'(1) << sbaccess_i) - BusWidth'(1);
  assign incr    = BusWidth'(1) << size_q;
  assign al_size = (state_q == Idle) ? sbaccess_i : size_q;
  assign al_off  = (state_q == Idle) ? taddr[OW-1:0] : off_q;

  dm_sba_align #(
    .BusWidth(BusWidth)
  ) u_align (
    .size_i  (al_size),
    .offset_i(al_off),
    .wdata_i (sbdata_i),
    .rdata_i (r_rdata_i),
    .be_o    (al_be),
    .wdata_o (al_wdata),
    .rdata_o (al_rdata)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    baddr_d  = baddr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    size_d   = size_q;
    off_d    = off_q;
    err_d    = err_q;
    req_d    = req_q;
    we_d     = we_q;
    abort_d  = abort_q;
    dvalid_d = 1'b0;
    evalid_d = 1'b0;
    unique case (state_q)
      Idle: begin
        abort_d = 1'b0;
        if (sbaddress_write_valid_i) addr_d = sbaddress_i;
        if (trig_wr || trig_rd) begin
          if (sbaccess_i > 3'(OW)) begin
            evalid_d = 1'b1;
            err_d    = SbErrSize;
          end else if ((taddr & lowmask) != '0) begin
            evalid_d = 1'b1;
            err_d    = SbErrAlign;
          end else begin
            state_d = trig_wr ? Write : Read;
            req_d   = 1'b1;
            we_d    = trig_wr;
            baddr_d = taddr & ~BusWidth'(NB - 1);
            wdata_d = al_wdata;
            be_d    = al_be;
            size_d  = sbaccess_i;
            off_d   = taddr[OW-1:0];
          end
        end
      end
      Read, Write: begin
        // A grant in the abort cycle still owes us a response to drain.
        if (gnt_i) begin
          req_d   = 1'b0;
          abort_d = ~dmactive_i;
          state_d = (state_q == Read) ? WaitRead : WaitWrite;
        end else if (!dmactive_i) begin
          req_d   = 1'b0;
          state_d = Idle;
        end
      end
      WaitRead, WaitWrite: begin
        if (!dmactive_i) abort_d = 1'b1;
        if (r_valid_i) begin
          state_d = Idle;
          abort_d = 1'b0;
          if (!abort_q && dmactive_i) begin
            if (resp_err) begin
              evalid_d = 1'b1;
              err_d    = SbErrBadAddr;
            end else begin
              if (state_q == WaitRead) begin
                data_d   = al_rdata;
                dvalid_d = 1'b1;
              end
              if (sbautoincrement_i) addr_d = addr_q + incr;
            end
          end
        end
      end
      default: state_d = Idle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= Idle;
      addr_q   <= '0;
      data_q   <= '0;
      baddr_q  <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      size_q   <= '0;
      off_q    <= '0;
      err_q    <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      dvalid_q <= 1'b0;
      evalid_q <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      baddr_q  <= baddr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      size_q   <= size_d;
      off_q    <= off_d;
      err_q    <= err_d;
      req_q    <= req_d;
      we_q     <= we_d;
      dvalid_q <= dvalid_d;
      evalid_q <= evalid_d;
      abort_q  <= abort_d;
    end
  end

  assign sbaddress_o     = addr_q;
  assign sbdata_o        = data_q;
  assign sbdata_valid_o  = dvalid_q;
  assign sbbusy_o        = (state_q != Idle);
  assign sberror_valid_o = evalid_q;
  assign sberror_o       = err_q;
  assign req_o           = req_q;
  assign we_o            = we_q;
  assign addr_o          = baddr_q;
  assign wdata_o         = wdata_q;
  assign be_o            = be_q;

endmodule

// File: tb/tb_dm_sba.sv
// Self-checking bench for dm_sba with a transaction-level expectation model.
// Build with DM_SBA_BUS_ERR_EN to exercise bus-error reporting.
module tb_dm_sba;

  localparam int BW = 32;
`ifdef DM_SBA_BUS_ERR_EN
  localparam bit BusErrEn = 1'b1;
`else
  localparam bit BusErrEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic dmactive_i, sbreadonaddr_i, sbreadondata_i, sbautoincrement_i;
  logic [2:0] sbaccess_i;
  logic [31:0] sbaddress_i, sbdata_i, r_rdata_i;
  logic sbaddress_write_valid_i, sbdata_write_valid_i, sbdata_read_valid_i;
  logic gnt_i, r_valid_i, r_err_i;
  logic [31:0] sbaddress_o, sbdata_o, addr_o, wdata_o;
  logic [3:0] be_o;
  logic [2:0] sberror_o;
  logic sbdata_valid_o, sbbusy_o, sberror_valid_o, req_o, we_o;

  dm_sba #(.BusWidth(BW)) dut (
    .clk_i(clk), .rst_i(rst), .dmactive_i(dmactive_i),
    .sbaccess_i(sbaccess_i), .sbreadonaddr_i(sbreadonaddr_i),
    .sbreadondata_i(sbreadondata_i),
    .sbautoincrement_i(sbautoincrement_i),
    .sbaddress_i(sbaddress_i),
    .sbaddress_write_valid_i(sbaddress_write_valid_i),
    .sbdata_i(sbdata_i), .sbdata_write_valid_i(sbdata_write_valid_i),
    .sbdata_read_valid_i(sbdata_read_valid_i),
    .sbaddress_o(sbaddress_o), .sbdata_o(sbdata_o),
    .sbdata_valid_o(sbdata_valid_o), .sbbusy_o(sbbusy_o),
    .sberror_valid_o(sberror_valid_o), .sberror_o(sberror_o),
    .req_o(req_o), .we_o(we_o), .addr_o(addr_o), .wdata_o(wdata_o),
    .be_o(be_o), .gnt_i(gnt_i), .r_valid_i(r_valid_i),
    .r_rdata_i(r_rdata_i), .r_err_i(r_err_i)
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  logic [31:0] exp_sbaddr = '0, exp_data = '0;
  logic [31:0] exp_addr = '0, exp_wdata = '0;
  logic [3:0]  exp_be = '0;
  logic [2:0]  exp_err = '0;
  logic exp_req = 0, exp_we = 0, exp_busy = 0;
  logic exp_dvalid = 0, exp_evalid = 0;
  logic [31:0] last_wdata;
  logic [3:0]  last_be;

  function automatic void chk(string n, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endfunction

  function automatic logic [3:0] m_be(logic [31:0] a, int sz);
    int nb;
    int off;
    nb  = 1 << sz;
    off = int'(a % 4);
    return 4'(((1 << nb) - 1) << off);
  endfunction

  function automatic logic [31:0] m_wdata(logic [31:0] d, int sz);
    if (sz == 0) return 32'(d[7:0]) * 32'h0101_0101;
    if (sz == 1) return 32'(d[15:0]) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_rdata(logic [31:0] r, logic [31:0] a,
                                          int sz);
    logic [63:0] v;
    logic [63:0] mask;
    v    = 64'(r) >> (8 * (a % 4));
    mask = (64'd1 << (8 << sz)) - 64'd1;
    return 32'(v & mask);
  endfunction

  function automatic int m_err(logic [31:0] a, int sz);
    if (sz > 2) return 4;
    if ((a % (32'd1 << sz)) != 0) return 3;
    return 0;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 64'(sbbusy_o), 64'(exp_busy));
      chk("req", 64'(req_o), 64'(exp_req));
      chk("sbaddress", 64'(sbaddress_o), 64'(exp_sbaddr));
      chk("sbdata", 64'(sbdata_o), 64'(exp_data));
      chk("dvalid", 64'(sbdata_valid_o), 64'(exp_dvalid));
      chk("evalid", 64'(sberror_valid_o), 64'(exp_evalid));
      if (exp_evalid) chk("errcode", 64'(sberror_o), 64'(exp_err));
      if (exp_req) begin
        chk("addr", 64'(addr_o), 64'(exp_addr));
        chk("be", 64'(be_o), 64'(exp_be));
        chk("we", 64'(we_o), 64'(exp_we));
        if (exp_we) chk("wdata", 64'(wdata_o), 64'(exp_wdata));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input logic [31:0] a);
    sbaddress_i = a;
    sbaddress_write_valid_i = 1'b1;
    sbreadonaddr_i = 1'b0;
    tick();
    sbaddress_write_valid_i = 1'b0;
    exp_sbaddr = a;
  endtask

  // kind: 0 write, 1 read-on-address, 2 read-on-data
  // abort: 0 none, 1 drop dmactive in wait, 2 drop while requesting
  task automatic access(input int kind, input logic [31:0] ad,
                        input int sz, input bit ai, input int gdly,
                        input int rdly, input logic [31:0] rdata,
                        input bit rerr, input int abort, input bit poke);
    logic [31:0] a;
    int e;
    bit rd;
    sbaccess_i = 3'(sz);
    sbautoincrement_i = ai;
    rd = (kind != 0);
    a = exp_sbaddr;
    if (kind == 0) begin
      sbdata_i = ad;
      sbdata_write_valid_i = 1'b1;
    end else if (kind == 1) begin
      a = ad;
      sbaddress_i = ad;
      sbreadonaddr_i = 1'b1;
      sbaddress_write_valid_i = 1'b1;
    end else begin
      sbreadondata_i = 1'b1;
      sbdata_read_valid_i = 1'b1;
    end
    e = m_err(a, sz);
    tick();
    sbdata_write_valid_i = 0;
    sbaddress_write_valid_i = 0;
    sbdata_read_valid_i = 0;
    sbreadonaddr_i = 0;
    sbreadondata_i = 0;
    if (kind == 1) exp_sbaddr = a;
    if (e != 0) begin
      exp_evalid = 1'b1;
      exp_err = 3'(e);
      tick();
      exp_evalid = 1'b0;
      return;
    end
    exp_req = 1'b1;
    exp_busy = 1'b1;
    exp_we = !rd;
    exp_addr = a & ~32'd3;
    exp_be = m_be(a, sz);
    exp_wdata = m_wdata(ad, sz);
    last_be = be_o;
    last_wdata = wdata_o;
    for (int i = 0; i < gdly; i++) begin
      sbdata_write_valid_i = poke && (i == 1);
      sbaddress_write_valid_i = poke && (i == 1);
      if (poke && i == 1) begin
        sbdata_i = 32'h5555_5555;
        sbaddress_i = 32'h0BAD_0000;
      end
      if (abort == 2 && i == gdly - 1) dmactive_i = 1'b0;
      tick();
    end
    sbdata_write_valid_i = 0;
    sbaddress_write_valid_i = 0;
    if (abort == 2) begin
      exp_req = 1'b0;
      exp_busy = 1'b0;
      dmactive_i = 1'b1;
      tick();
      return;
    end
    gnt_i = 1'b1;
    tick();
    gnt_i = 1'b0;
    exp_req = 1'b0;
    if (abort == 1) dmactive_i = 1'b0;
    for (int i = 0; i < rdly; i++) tick();
    r_valid_i = 1'b1;
    r_rdata_i = rdata;
    r_err_i = rerr;
    tick();
    r_valid_i = 1'b0;
    r_err_i = 1'b0;
    exp_busy = 1'b0;
    if (abort == 1) begin
      dmactive_i = 1'b1;
      tick();
      return;
    end
    if (rerr && BusErrEn) begin
      exp_evalid = 1'b1;
      exp_err = 3'd2;
      tick();
      exp_evalid = 1'b0;
      return;
    end
    if (rd) begin
      exp_data = m_rdata(rdata, a, sz);
      exp_dvalid = 1'b1;
    end
    if (ai) exp_sbaddr = a + (32'd1 << sz);
    tick();
    exp_dvalid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, limit 200000");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    dmactive_i = 1'b1;
    sbaccess_i = 3'd2;
    sbreadonaddr_i = 0;
    sbreadondata_i = 0;
    sbautoincrement_i = 0;
    sbaddress_i = '0;
    sbdata_i = '0;
    sbaddress_write_valid_i = 0;
    sbdata_write_valid_i = 0;
    sbdata_read_valid_i = 0;
    gnt_i = 0;
    r_valid_i = 0;
    r_rdata_i = '0;
    r_err_i = 0;
    tick();
    chk_en = 1'b1;
    tick();
    tick();
    chk("rst_addr_o", 64'(addr_o), 64'd0);
    chk("rst_wdata_o", 64'(wdata_o), 64'd0);
    chk("rst_be_o", 64'(be_o), 64'd0);
    chk("rst_we_o", 64'(we_o), 64'd0);
    chk("rst_sberror_o", 64'(sberror_o), 64'd0);
    rst = 1'b0;
    tick();

    access(1, 32'h1004, 2, 0, 0, 0, 32'hDEAD_BEEF, 0, 0, 0);
    chk("lit_rd_data", 64'(sbdata_o), 64'hDEAD_BEEF);
    chk("lit_rd_be", 64'(last_be), 64'hF);

    set_addr(32'h2003);
    access(0, 32'hA5, 0, 1, 0, 1, 32'h0, 0, 0, 0);
    chk("lit_wr_be", 64'(last_be), 64'h8);
    chk("lit_wr_wdata", 64'(last_wdata), 64'hA5A5_A5A5);
    chk("lit_wr_incr", 64'(sbaddress_o), 64'h2004);

    set_addr(32'h1002);
    access(2, 32'h0, 2, 0, 0, 0, 32'h0, 0, 0, 0);
    access(1, 32'h1006, 2, 0, 0, 0, 32'h0, 0, 0, 0);
    access(2, 32'h0, 3, 0, 0, 0, 32'h0, 0, 0, 0);
    access(0, 32'h1234, 2, 0, 0, 0, 32'h0, 0, 0, 0);

    access(2, 32'h0, 1, 0, 1, 0, 32'h1234_5678, 0, 0, 0);
    chk("lit_half_rd", 64'(sbdata_o), 64'h1234);
    access(1, 32'h1001, 0, 0, 0, 2, 32'h1234_5678, 0, 0, 0);
    chk("lit_byte_rd", 64'(sbdata_o), 64'h56);

    set_addr(32'hFFFF_FFFC);
    access(2, 32'h0, 2, 1, 0, 0, 32'h0BAD_F00D, 0, 0, 0);
    chk("lit_wrap", 64'(sbaddress_o), 64'h0);

    access(0, 32'h1122_3344, 2, 0, 5, 2, 32'h0, 0, 0, 1);

    set_addr(32'h3000);
    access(2, 32'h0, 2, 1, 0, 3, 32'hCAFE_F00D, 0, 1, 0);
    chk("lit_abort_addr", 64'(sbaddress_o), 64'h3000);
    access(2, 32'h0, 2, 0, 3, 0, 32'h0, 0, 2, 0);

    access(2, 32'h0, 2, 1, 0, 1, 32'h0000_0077, 1, 0, 0);

    set_addr(32'h3002);
    access(0, 32'hBEEF, 1, 1, 1, 0, 32'h0, 0, 0, 0);
    chk("lit_half_be", 64'(last_be), 64'hC);
    chk("lit_half_wd", 64'(last_wdata), 64'hBEEF_BEEF);

    tick();
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
